cache_bus_arbiter: RTL and testbench
====================================

// Module: cache_bus_arbiter
// PURPOSE
//  Shares one cache_bus slave port (toward the AXI bridge) between NUM_MASTER cache_bus
//  masters, e.g. icache (port 0) and dcache (port 1). It arbitrates among pending requests
//  and locks the grant for one whole transaction: address handshake through the last data beat.
//  Non-granted masters stall because they receive ready=0 and data_ok=0.
// PARAMETERS
//  NUM_MASTER   2  number of requesting cache_bus masters (>=2)
//  FIXED_PRIO   0  0: round-robin; 1: fixed priority, lowest index wins
// PORTS
//  clk      in   1                               clock; all state updates on posedge
//  rst_n    in   1                               asynchronous reset, active-low
//  req_i    in   cache_bus_req_t  [NUM_MASTER]   requests from masters
//  resp_o   out  cache_bus_resp_t [NUM_MASTER]   responses to masters
//  req_o    out  cache_bus_req_t                 request to shared slave
//  resp_i   in   cache_bus_resp_t                response from shared slave
//  grant_o  out  [$clog2(NUM_MASTER)-1:0]        currently/last granted master index
//  busy_o   out  1                               1 while state != IDLE
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, grant=0, rr_ptr=0; req_o all-zero;
//    resp_o[*].ready/data_ok/data_last=0; busy_o=0; grant_o=0.
//  - FSM, one-hot 3 bits: IDLE=3'b001, ADDR=3'b010, DATA=3'b100.
//  - IDLE:
//    - req_o is all-zero.
//    - If any req_i[k].valid: register the winner into grant and go to ADDR next cycle.
//      Arbitration latency is 1 cycle.
//    - Round-robin winner: first valid index searching from rr_ptr upward, with modulo wrap.
//    - Fixed-priority winner: lowest valid index.
//  - ADDR:
//    - req_o = req_i[grant], field by field.
//    - resp_o[grant].ready = resp_i.ready.
//    - On resp_i.ready & req_o.valid, go to DATA.
//    - If req_i[grant].valid drops before ready, return to IDLE and do not update rr_ptr.
//  - DATA:
//    - req_o = req_i[grant]. req_o.valid is forced to 0, so the slave sees no second address.
//    - resp_o[grant].data_ok = resp_i.data_ok; resp_o[grant].data_last = resp_i.data_last.
//    - done = resp_i.data_ok & req_o.data_ok & resp_i.data_last.
//    - On done: go to IDLE; rr_ptr <= (grant==NUM_MASTER-1) ? 0 : grant+1.
//  - resp_o[*].r_data = resp_i.r_data, broadcast to all masters.
//    ready/data_ok/data_last to non-granted masters are always 0.
//  - Writes and reads share the same path. w_data, data_strobe, data_last, burst and cached
//    pass through unmodified from the granted master.
//  - The grant never changes while state != IDLE, regardless of new requests.
//    A new arbitration happens only in IDLE, so transactions are separated by >=1 idle cycle.
//  - Simultaneous requests in IDLE: exactly one wins; the losers keep valid asserted and
//    win in a later IDLE.
//  - Reset asserted mid-transaction: the FSM aborts immediately to IDLE and outputs return
//    to reset values. The slave and masters are reset by the same rst_n.
//  - grant_o holds the last grant while IDLE. busy_o = (state != IDLE).
// TESTING
//  1. Single master: req_i[0] read, ready after 2 cycles, 1 beat r_data=32'hDEADBEEF
//     -> resp_o[0] data_ok for 1 cycle with that data; resp_o[1] stays 0; back to IDLE.
//  2. Both masters valid in the same cycle after reset (rr_ptr=0) -> 0 served first, then 1.
//     A third simultaneous request pair -> 0 again, proving rotation.
//  3. FIXED_PRIO=1: master 0 re-requests continuously while master 1 waits
//     -> master 1 is never granted while 0 is valid in IDLE.
//  4. Burst read of 4 beats with data_last on the 4th, and master 1 asserting valid mid-burst
//     -> grant stays 0 for all 4 beats; master 1 sees ready=0 until the next IDLE.
//  5. Write from master 1: w_data=32'h12345678, strobe=4'hF
//     -> req_o carries exactly those values; done on resp data_ok&data_last.
//  6. rst_n deasserted... asserted low during DATA beat 2 of 4
//     -> same cycle req_o=0, busy_o=0; after release the arbiter grants from rr_ptr=0.

Source files
------------

// File: rtl/cache_bus_arbiter_if.sv
// cache_bus request/response types and the bundle that carries the shared-slave
// arbiter's master-facing and slave-facing buses.
package cache_bus_pkg;

  typedef struct packed {
    logic        valid;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [1:0]  burst;
    logic        cached;
    logic [31:0] w_data;
    logic [3:0]  data_strobe;
    logic        data_ok;
    logic        data_last;
  } cache_bus_req_t;

  typedef struct packed {
    logic        ready;
    logic        data_ok;
    logic        data_last;
    logic [31:0] r_data;
  } cache_bus_resp_t;

endpackage

interface cache_bus_arbiter_if #(
  parameter int NUM_MASTER = 2
);
  import cache_bus_pkg::*;

  cache_bus_req_t  req_i  [NUM_MASTER];
  cache_bus_resp_t resp_o [NUM_MASTER];
  cache_bus_req_t  req_o;
  cache_bus_resp_t resp_i;

  // slave: the arbiter; master: the cache masters together with the shared bridge
  modport slave  (input req_i, output resp_o, output req_o, input resp_i);
  modport master (output req_i, input resp_o, input req_o, output resp_i);
endinterface

// File: rtl/cache_bus_arbiter.sv
// Purpose: shares one cache_bus slave among NUM_MASTER masters, grant locked per transaction.
// Latency: 1 idle cycle to arbitrate, then address and data pass straight through.
// Backpressure: losers see ready=0/data_ok=0; the granted master sees the slave's handshakes.
module cache_bus_arbiter
  import cache_bus_pkg::*;
#(
  parameter int NUM_MASTER = 2,
  parameter int FIXED_PRIO = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  cache_bus_arbiter_if.slave            bus,
  output logic [$clog2(NUM_MASTER)-1:0] grant_o,
  output logic                          busy_o
);

  localparam int GW = $clog2(NUM_MASTER);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    ADDR = 3'b010,
    DATA = 3'b100
  } state_t;

  state_t         state;
  logic [GW-1:0]  grant;
  logic [GW-1:0]  rr_ptr;
  logic [GW-1:0]  base;
  logic [GW:0]    cand;
  logic           win_vld;
  logic [GW-1:0]  win_idx;
  cache_bus_req_t req_g;
  logic           done;

  assign base  = (FIXED_PRIO != 0) ? '0 : rr_ptr;
  assign req_g = bus.req_i[grant];
  assign done  = bus.resp_i.data_ok & req_g.data_ok & bus.resp_i.data_last;

  // Scan from the top of the search order down so the earliest candidate wins last.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = NUM_MASTER - 1; i >= 0; i--) begin
      cand = {1'b0, base} + (GW+1)'(i);
      if (cand >= (GW+1)'(NUM_MASTER)) begin
        cand = cand - (GW+1)'(NUM_MASTER);
      end
      if (bus.req_i[cand[GW-1:0]].valid) begin
        win_vld = 1'b1;
        win_idx = cand[GW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            grant <= win_idx;
            state <= ADDR;
          end
        end
        ADDR: begin
          // An abandoned address phase leaves rr_ptr alone: nothing was served.
          if (!req_g.valid) begin
            state <= IDLE;
          end else if (bus.resp_i.ready) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (done) begin
            state  <= IDLE;
            rr_ptr <= (grant == GW'(NUM_MASTER - 1)) ? '0 : grant + GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.req_o = '0;
    for (int k = 0; k < NUM_MASTER; k++) begin
      bus.resp_o[k]        = '0;
      bus.resp_o[k].r_data = bus.resp_i.r_data;
    end
    case (state)
      ADDR: begin
        bus.req_o              = req_g;
        bus.resp_o[grant].ready = bus.resp_i.ready;
      end
      DATA: begin
        // Address already accepted; keep the slave from seeing a second one.
        bus.req_o                   = req_g;
        bus.req_o.valid             = 1'b0;
        bus.resp_o[grant].data_ok   = bus.resp_i.data_ok;
        bus.resp_o[grant].data_last = bus.resp_i.data_last;
      end
      default: ;
    endcase
  end

  assign grant_o = grant;
  assign busy_o  = (state != IDLE);

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter with identical stimulus and checks
// both every cycle against a transaction-level model, plus directed literal checks.
module tb_cache_bus_arbiter;
  import cache_bus_pkg::*;

  localparam int NM = 3;
  localparam int GW = $clog2(NM);

  logic clk = 1'b0;
  logic rst_n;
  cache_bus_req_t  req_drv [NM];
  cache_bus_resp_t resp_drv;
  logic [GW-1:0] grant_rr, grant_fp;
  logic          busy_rr, busy_fp;

  cache_bus_arbiter_if #(.NUM_MASTER(NM)) bus_rr ();
  cache_bus_arbiter_if #(.NUM_MASTER(NM)) bus_fp ();

  for (genvar k = 0; k < NM; k++) begin : g_drv
    assign bus_rr.req_i[k] = req_drv[k];
    assign bus_fp.req_i[k] = req_drv[k];
  end
  assign bus_rr.resp_i = resp_drv;
  assign bus_fp.resp_i = resp_drv;

  cache_bus_arbiter #(.NUM_MASTER(NM), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .bus(bus_rr.slave), .grant_o(grant_rr), .busy_o(busy_rr));
  cache_bus_arbiter #(.NUM_MASTER(NM), .FIXED_PRIO(1)) u_fp (
    .clk(clk), .rst_n(rst_n), .bus(bus_fp.slave), .grant_o(grant_fp), .busy_o(busy_fp));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model per instance (0 = round-robin, 1 = fixed priority): who owns the bus
  // (-1 = nobody), whether its address was accepted, last grant, next rr start.
  int m_owner [2];
  bit m_data  [2];
  int m_last  [2];
  int m_rr    [2];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset(input int d);
    m_owner[d] = -1;
    m_data[d]  = 1'b0;
    m_last[d]  = 0;
    m_rr[d]    = 0;
  endtask

  task automatic model_step();
    int o, start, j;
    bit found;
    for (int d = 0; d < 2; d++) begin
      o = m_owner[d];
      if (!rst_n) begin
        model_reset(d);
      end else if (o < 0) begin
        start = (d == 1) ? 0 : m_rr[d];
        found = 1'b0;
        for (int i = 0; i < NM; i++) begin
          j = (start + i) % NM;
          if (!found && req_drv[j].valid) begin
            found      = 1'b1;
            m_owner[d] = j;
            m_last[d]  = j;
            m_data[d]  = 1'b0;
          end
        end
      end else if (!m_data[d]) begin
        if (!req_drv[o].valid) m_owner[d] = -1;
        else if (resp_drv.ready) m_data[d] = 1'b1;
      end else if (resp_drv.data_ok && req_drv[o].data_ok && resp_drv.data_last) begin
        m_rr[d]    = (o + 1) % NM;
        m_owner[d] = -1;
      end
    end
  endtask

  task automatic compare_all();
    cache_bus_req_t  er, ar;
    cache_bus_resp_t eresp, aresp;
    logic [GW-1:0]   ag;
    logic            ab;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) model_reset(d);
      er = '0;
      if (m_owner[d] >= 0) begin
        er = req_drv[m_owner[d]];
        if (m_data[d]) er.valid = 1'b0;
      end
      ar = (d == 0) ? bus_rr.req_o : bus_fp.req_o;
      ag = (d == 0) ? grant_rr : grant_fp;
      ab = (d == 0) ? busy_rr : busy_fp;
      chk($sformatf("d%0d req_o", d), 128'(ar), 128'(er));
      chk($sformatf("d%0d busy_o", d), 128'(ab), 128'(m_owner[d] >= 0));
      chk($sformatf("d%0d grant_o", d), 128'(ag), 128'(m_last[d]));
      for (int k = 0; k < NM; k++) begin
        eresp        = '0;
        eresp.r_data = resp_drv.r_data;
        if (m_owner[d] == k) begin
          if (!m_data[d]) begin
            eresp.ready = resp_drv.ready;
          end else begin
            eresp.data_ok   = resp_drv.data_ok;
            eresp.data_last = resp_drv.data_last;
          end
        end
        aresp = (d == 0) ? bus_rr.resp_o[k] : bus_fp.resp_o[k];
        chk($sformatf("d%0d resp_o[%0d]", d, k), 128'(aresp), 128'(eresp));
      end
    end
  endtask

  task automatic half();
    @(negedge clk);
    compare_all();
  endtask

  task automatic adv();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cyc();
    half();
    adv();
  endtask

  task automatic clr();
    for (int k = 0; k < NM; k++) req_drv[k] = '0;
    resp_drv = '0;
  endtask

  function automatic cache_bus_req_t rand_req();
    cache_bus_req_t r;
    r.valid       = 1'($urandom);
    r.wr          = 1'($urandom);
    r.size        = 2'($urandom);
    r.addr        = $urandom;
    r.burst       = 2'($urandom);
    r.cached      = 1'($urandom);
    r.w_data      = $urandom;
    r.data_strobe = 4'($urandom);
    r.data_ok     = 1'($urandom);
    r.data_last   = 1'($urandom);
    return r;
  endfunction

  int  rr_seq [$];
  int  fp_seq [$];
  bit  prev_rr, prev_fp;
  int  fp_bad;
  logic v;

  initial begin
    model_reset(0);
    model_reset(1);
    clr();
    rst_n = 1'b0;
    #1;
    half();
    chk("rst_busy", 128'(busy_rr), 128'(0));
    chk("rst_grant", 128'(grant_rr), 128'(0));
    chk("rst_req_o", 128'(bus_rr.req_o), 128'(0));
    adv();
    rst_n = 1'b1;
    cyc();

    // Single read from master 0, ready after two cycles, one beat.
    req_drv[0].valid = 1'b1;
    req_drv[0].addr  = 32'h0000_1000;
    cyc();
    half();
    chk("t1_busy", 128'(busy_rr), 128'(1));
    chk("t1_ready_low", 128'(bus_rr.resp_o[0].ready), 128'(0));
    adv();
    cyc();
    resp_drv.ready = 1'b1;
    half();
    chk("t1_ready", 128'(bus_rr.resp_o[0].ready), 128'(1));
    chk("t1_addr", 128'(bus_rr.req_o.addr), 128'(32'h0000_1000));
    adv();
    resp_drv = '0;
    req_drv[0].valid   = 1'b0;
    req_drv[0].data_ok = 1'b1;
    resp_drv.data_ok   = 1'b1;
    resp_drv.data_last = 1'b1;
    resp_drv.r_data    = 32'hDEAD_BEEF;
    half();
    chk("t1_data_ok", 128'(bus_rr.resp_o[0].data_ok), 128'(1));
    chk("t1_r_data", 128'(bus_rr.resp_o[0].r_data), 128'(32'hDEAD_BEEF));
    chk("t1_m1_quiet", 128'(bus_rr.resp_o[1].data_ok), 128'(0));
    chk("t1_no_readdr", 128'(bus_rr.req_o.valid), 128'(0));
    adv();
    clr();
    half();
    chk("t1_idle", 128'(busy_rr), 128'(0));
    adv();

    // Write from master 1.
    req_drv[1].valid       = 1'b1;
    req_drv[1].wr          = 1'b1;
    req_drv[1].addr        = 32'h0000_2000;
    req_drv[1].w_data      = 32'h1234_5678;
    req_drv[1].data_strobe = 4'hF;
    cyc();
    resp_drv.ready = 1'b1;
    half();
    chk("t5_grant", 128'(grant_rr), 128'(1));
    chk("t5_w_data", 128'(bus_rr.req_o.w_data), 128'(32'h1234_5678));
    chk("t5_strobe", 128'(bus_rr.req_o.data_strobe), 128'(4'hF));
    adv();
    resp_drv = '0;
    req_drv[1].valid     = 1'b0;
    req_drv[1].data_ok   = 1'b1;
    req_drv[1].data_last = 1'b1;
    half();
    chk("t5_wait_busy", 128'(busy_rr), 128'(1));
    adv();
    resp_drv.data_ok   = 1'b1;
    resp_drv.data_last = 1'b1;
    cyc();
    clr();
    half();
    chk("t5_done", 128'(busy_rr), 128'(0));
    adv();

    // Four-beat burst from master 0; master 1 arrives mid-burst.
    req_drv[0].valid = 1'b1;
    req_drv[0].burst = 2'd2;
    cyc();
    resp_drv.ready = 1'b1;
    cyc();
    req_drv[0].valid   = 1'b0;
    req_drv[0].data_ok = 1'b1;
    req_drv[1].valid   = 1'b1;
    req_drv[1].addr    = 32'h0000_4000;
    for (int beat = 1; beat <= 4; beat++) begin
      resp_drv.data_ok   = 1'b1;
      resp_drv.data_last = (beat == 4);
      resp_drv.r_data    = 32'hA0 + beat;
      half();
      chk("t4_grant", 128'(grant_rr), 128'(0));
      chk("t4_m1_ready", 128'(bus_rr.resp_o[1].ready), 128'(0));
      chk("t4_last", 128'(bus_rr.resp_o[0].data_last), 128'(beat == 4));
      adv();
    end
    req_drv[0] = '0;
    resp_drv   = '0;
    half();
    chk("t4_idle_gap", 128'(busy_rr), 128'(0));
    adv();
    half();
    chk("t4_m1_grant", 128'(grant_rr), 128'(1));
    adv();
    req_drv[1].valid = 1'b0;
    cyc();
    half();
    chk("t4_abandon", 128'(busy_rr), 128'(0));
    adv();

    // Reset during beat 2 of a burst; afterwards arbitration restarts at master 0.
    req_drv[0].valid = 1'b1;
    cyc();
    resp_drv.ready = 1'b1;
    cyc();
    resp_drv = '0;
    req_drv[0].valid   = 1'b0;
    req_drv[0].data_ok = 1'b1;
    resp_drv.data_ok   = 1'b1;
    cyc();
    rst_n = 1'b0;
    half();
    chk("t6_req_o", 128'(bus_rr.req_o), 128'(0));
    chk("t6_busy", 128'(busy_rr), 128'(0));
    adv();
    rst_n = 1'b1;

    // Masters 0 and 1 request continuously with an always-ready slave.
    clr();
    for (int k = 0; k < 2; k++) begin
      req_drv[k].valid   = 1'b1;
      req_drv[k].data_ok = 1'b1;
    end
    resp_drv.ready     = 1'b1;
    resp_drv.data_ok   = 1'b1;
    resp_drv.data_last = 1'b1;
    prev_rr = 1'b0;
    prev_fp = 1'b0;
    fp_bad  = 0;
    for (int c = 0; c < 40; c++) begin
      half();
      if (busy_rr && !prev_rr) rr_seq.push_back(int'(grant_rr));
      if (busy_fp && !prev_fp) fp_seq.push_back(int'(grant_fp));
      if (busy_fp && grant_fp != 0) fp_bad++;
      prev_rr = busy_rr;
      prev_fp = busy_fp;
      adv();
    end
    chk("t2_rr_count", 128'(rr_seq.size() >= 3), 128'(1));
    while (rr_seq.size() < 3) rr_seq.push_back(-1);
    chk("t2_rr_first", 128'(rr_seq[0]), 128'(0));
    chk("t2_rr_second", 128'(rr_seq[1]), 128'(1));
    chk("t2_rr_third", 128'(rr_seq[2]), 128'(0));
    chk("t3_fp_count", 128'(fp_seq.size() >= 5), 128'(1));
    chk("t3_fp_never_1", 128'(fp_bad), 128'(0));

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      for (int k = 0; k < NM; k++) begin
        v = req_drv[k].valid;
        req_drv[k] = rand_req();
        req_drv[k].valid = ($urandom_range(0, 3) == 0) ? ~v : v;
      end
      resp_drv.ready     = 1'($urandom);
      resp_drv.data_ok   = 1'($urandom);
      resp_drv.data_last = 1'($urandom);
      resp_drv.r_data    = $urandom;
      cyc();
    end

    rst_n = 1'b1;
    clr();
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
